fifo_wr_arbiter: RTL and testbench

- Write-side scheduler for the async FIFO. Shares the FIFO write port (wdata/winc/wfull, wclk domain) between NREQ requesters using round-robin.
- One-entry holding register decouples requester handshakes from wfull: one beat per wclk when the FIFO is not full, and no write is ever issued while wfull=1.
- Sits between the producer blocks and the FIFO top in the write clock domain.

---
 rtl/fifo_arb_pkg.sv | 26 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 48 ++++
 rtl/fifo_wr_arbiter.sv | 126 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared constants, width helper and hold-entry type for fifo_wr_arbiter
//
// Purpose: default sizing for the FIFO write-side arbiter and the entry type
// that describes one beat sitting in the holding register.
// Ports: none (package).
package fifo_arb_pkg;

  localparam int NREQ_DEF     = 4;
  localparam int DATASIZE_DEF = 40;

  // Bits needed to index n requesters; never less than one bit.
  function automatic int arb_clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  localparam int IDW_DEF = arb_clog2(NREQ_DEF);

  typedef struct packed {
    logic [IDW_DEF-1:0]      id;
    logic [DATASIZE_DEF-1:0] data;
  } hold_entry_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin picker
//
// Purpose: finds the first eligible requester starting at ptr and wrapping
// from N-1 back to 0. Eligible means req & mask.
// Ports:
//   req   [N]  requests
//   ptr   [IW] search start position (0..N-1)
//   mask  [N]  eligibility mask
//   grant [N]  one-hot winner (zero when none)
//   idx   [IW] winner index (zero when none)
//   any   [1]  a winner exists
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = NREQ_DEF,
  parameter int IW = arb_clog2(NREQ_DEF)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0] elig;

  assign elig = req & mask;

  always_comb begin
    int pos;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      // ptr < N and k < N, so one subtraction is enough to wrap.
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!any && elig[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write-port scheduler in front of the async FIFO
//
// Purpose: shares the FIFO write port between NREQ requesters through a
// one-entry holding register. One beat per wclk while wfull=0; no write is
// ever issued while wfull=1.
// Optional feature macro: ARB_PKT_LOCK_EN (packet lock: a requester keeps the
// port from its first beat until its req_last beat, so packets never interleave).
// Ports:
//   wclk       [1]             write-domain clock
//   rst_n      [1]             asynchronous active-low reset
//   req_valid  [NREQ]          per-requester beat valid
//   req_data   [NREQ*DATASIZE] requester i at [i*DATASIZE +: DATASIZE]
//   req_last   [NREQ]          last beat of packet (packet lock only)
//   req_ready  [NREQ]          one-hot accept
//   wfull      [1]             FIFO full flag
//   wdata      [DATASIZE]      FIFO write data (holding register)
//   winc       [1]             FIFO write strobe
//   grant_id   [IDW]           requester id of the held beat
//   busy       [1]             holding register occupied
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int DATASIZE = DATASIZE_DEF,
  parameter int IDW      = arb_clog2(NREQ)
) (
  input  logic                     wclk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wfull,
  output logic [DATASIZE-1:0]      wdata,
  output logic                     winc,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy
);

  logic                hold_valid;
  logic [DATASIZE-1:0] hold_data;
  logic [IDW-1:0]      hold_id;
  logic [IDW-1:0]      rr_ptr;

  logic                load;
  logic                accept;
  logic [NREQ-1:0]     mask;
  logic                advance;
  logic [NREQ-1:0]     pick_grant;
  logic [IDW-1:0]      pick_idx;
  logic                pick_any;
  logic [DATASIZE-1:0] win_data;
  logic [IDW-1:0]      next_ptr;

  assign winc = hold_valid & ~wfull;
  // The hold can take a new beat when empty or when it drains this cycle.
  assign load = ~hold_valid | winc;

  rr_pick #(
    .N  (NREQ),
    .IW (IDW)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .mask  (mask),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // rst_n gate keeps ready low while reset is asserted even though the
  // cleared hold would otherwise allow a load.
  assign req_ready = (load && rst_n) ? pick_grant : '0;
  assign accept    = load & pick_any;
  assign win_data  = req_data[int'(pick_idx)*DATASIZE +: DATASIZE];
  assign next_ptr  = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + IDW'(1);

`ifdef ARB_PKT_LOCK_EN
  logic           lock;
  logic [IDW-1:0] lock_id;
  logic           win_last;

  assign win_last = req_last[pick_idx];
  // While a packet is open only its owner is eligible, even if it idles.
  assign mask     = lock ? (NREQ'(1) << lock_id) : {NREQ{1'b1}};
  // The pointer only moves at packet boundaries.
  assign advance  = win_last;

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      lock    <= 1'b0;
      lock_id <= '0;
    end else if (accept) begin
      lock    <= ~win_last;
      lock_id <= pick_idx;
    end
  end
`else
  logic unused_last;

  assign unused_last = ^req_last;
  assign mask        = {NREQ{1'b1}};
  assign advance     = 1'b1;
`endif

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_id    <= '0;
      rr_ptr     <= '0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_data  <= win_data;
      hold_id    <= pick_idx;
      if (advance) rr_ptr <= next_ptr;
    end else if (winc) begin
      hold_valid <= 1'b0;
    end
  end

  assign wdata    = hold_data;
  assign grant_id = hold_id;
  assign busy     = hold_valid;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N  = NREQ_DEF;
  localparam int DW = DATASIZE_DEF;
  localparam int IW = IDW_DEF;

  logic            wclk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            wfull;
  logic [DW-1:0]   wdata;
  logic            winc;
  logic [IW-1:0]   grant_id;
  logic            busy;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(.NREQ(N), .DATASIZE(DW), .IDW(IW)) dut (
    .wclk      (wclk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .wfull     (wfull),
    .wdata     (wdata),
    .winc      (winc),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] d);
    req_data[i*DW +: DW] = d;
  endtask

  // Reference model: the hold is a queue of at most one entry, the pointer
  // and lock owner are plain integers (-1 = no lock).
  hold_entry_t m_q[$];
  int          m_rr;
  int          m_lock;

  task automatic model_reset();
    m_q.delete();
    m_rr   = 0;
    m_lock = -1;
  endtask

  task automatic model_check();
    logic [N-1:0] e_ready;
    logic         e_winc;
    bit           room;
    int           w;
    int           i;
    hold_entry_t  e;
    e_winc  = (m_q.size() != 0) && !wfull;
    room    = (m_q.size() == 0) || e_winc;
    e_ready = '0;
    w       = -1;
    if (room) begin
      for (int k = 0; k < N; k++) begin
        i = (m_rr + k) % N;
        if (w < 0 && req_valid[i] && (m_lock < 0 || m_lock == i)) w = i;
      end
    end
    if (w >= 0) e_ready[w] = 1'b1;
    chk("rnd_ready", req_ready, e_ready);
    chk("rnd_winc", winc, e_winc);
    chk("rnd_busy", busy, m_q.size() != 0);
    if (e_winc) begin
      chk("rnd_wdata", wdata, m_q[0].data);
      chk("rnd_gid", grant_id, m_q[0].id);
      void'(m_q.pop_front());
    end
    if (w >= 0) begin
      e.id   = IW'(w);
      e.data = req_data[w*DW +: DW];
      m_q.push_back(e);
`ifdef ARB_PKT_LOCK_EN
      if (req_last[w]) begin
        m_lock = -1;
        m_rr   = (w + 1) % N;
      end else begin
        m_lock = w;
      end
`else
      m_rr = (w + 1) % N;
`endif
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    wfull     = 1'b0;
    @(posedge wclk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic cyc();
    @(posedge wclk); #1;
  endtask

  typedef struct {
    logic [N-1:0]  valid;
    logic          full;
    logic [N-1:0]  ready;
    logic          winc;
    logic          busy;
    logic [DW-1:0] data;
    logic [IW-1:0] gid;
  } vec_t;

  function automatic vec_t mk(logic [3:0] v, logic f, logic [3:0] r, logic wi, logic b,
                              logic [39:0] d, logic [1:0] g);
    vec_t t;
    t.valid = v; t.full = f; t.ready = r; t.winc = wi; t.busy = b; t.data = d; t.gid = g;
    return t;
  endfunction

  vec_t tbl[16];

  initial begin
    int          sent, written, first_c, last_c, n_w, r0_left, r0_sent, r1_sent;
    bit          pkt_start;
    logic [IW-1:0] ids[5];
    logic [IW-1:0] exp_ids[5];
    bit          hs[N];

    tbl[0]  = mk(4'b1111, 0, 4'b0001, 0, 0, 40'h0,  2'd0);
    tbl[1]  = mk(4'b1111, 0, 4'b0010, 1, 1, 40'hA0, 2'd0);
    tbl[2]  = mk(4'b1111, 0, 4'b0100, 1, 1, 40'hA1, 2'd1);
    tbl[3]  = mk(4'b1111, 0, 4'b1000, 1, 1, 40'hA2, 2'd2);
    tbl[4]  = mk(4'b1111, 0, 4'b0001, 1, 1, 40'hA3, 2'd3);
    tbl[5]  = mk(4'b0000, 0, 4'b0000, 1, 1, 40'hA0, 2'd0);
    tbl[6]  = mk(4'b0000, 0, 4'b0000, 0, 0, 40'h0,  2'd0);
    tbl[7]  = mk(4'b0100, 1, 4'b0100, 0, 0, 40'h0,  2'd0);
    for (int r = 8; r < 13; r++) tbl[r] = mk(4'b1111, 1, 4'b0000, 0, 1, 40'hA2, 2'd2);
    tbl[13] = mk(4'b1111, 0, 4'b1000, 1, 1, 40'hA2, 2'd2);
    tbl[14] = mk(4'b0000, 0, 4'b0000, 1, 1, 40'hA3, 2'd3);
    tbl[15] = mk(4'b0000, 0, 4'b0000, 0, 0, 40'h0,  2'd0);

    // Reset with every requester valid, then strict rotation and wfull stall.
    rst_n     = 1'b0;
    req_valid = '1;
    req_last  = '1;
    wfull     = 1'b0;
    for (int i = 0; i < N; i++) set_data(i, DW'(8'hA0 + i));
    #3;
    chk("rst_winc", winc, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    @(posedge wclk); #1;
    rst_n = 1'b1;
    for (int r = 0; r < 16; r++) begin
      if (r > 0) cyc();
      req_valid = tbl[r].valid;
      wfull     = tbl[r].full;
      #2;
      chk($sformatf("tbl%0d_ready", r), req_ready, tbl[r].ready);
      chk($sformatf("tbl%0d_winc", r), winc, tbl[r].winc);
      chk($sformatf("tbl%0d_busy", r), busy, tbl[r].busy);
      if (tbl[r].busy) begin
        chk($sformatf("tbl%0d_wdata", r), wdata, tbl[r].data);
        chk($sformatf("tbl%0d_gid", r), grant_id, tbl[r].gid);
      end
    end

    // Single requester streams back-to-back.
    do_reset();
    sent = 0; written = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 30; c++) begin
      cyc();
      req_valid = (sent < 8) ? 4'b0100 : 4'b0000;
      set_data(2, DW'(40'h100 + sent));
      #2;
      if (winc) begin
        chk("solo_wdata", wdata, 40'h100 + written);
        chk("solo_gid", grant_id, 2);
        if (written == 0) first_c = c;
        last_c = c;
        written++;
      end
      if (req_valid[2] && req_ready[2]) sent++;
    end
    chk("solo_count", written, 8);
    chk("solo_span", last_c - first_c, 7);

    // Reset while a beat is held behind wfull: it must vanish, pointer resets.
    do_reset();
    cyc();
    req_valid = 4'b0010;
    set_data(1, 40'h55);
    wfull = 1'b1;
    cyc();
    req_valid = 4'b0000;
    #2;
    chk("mid_busy_pre", busy, 1);
    chk("mid_winc_pre", winc, 0);
    chk("mid_wdata_pre", wdata, 40'h55);
    rst_n = 1'b0;
    #1;
    chk("mid_winc_rst", winc, 0);
    chk("mid_busy_rst", busy, 0);
    cyc();
    rst_n = 1'b1;
    wfull = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #2;
      chk("mid_no_write", winc, 0);
      cyc();
    end
    req_valid = 4'b1111;
    #2;
    chk("mid_ptr0", req_ready, 4'b0001);

    // Three-beat packet from requester 1 competing with requester 0.
    do_reset();
    r0_left = 2; r0_sent = 0; r1_sent = 0; pkt_start = 0; n_w = 0;
    for (int c = 0; c < 30; c++) begin
      cyc();
      req_valid[0] = (r0_left > 0);
      set_data(0, DW'(40'hB0 + r0_sent));
      req_last[0]  = 1'b1;
      req_valid[1] = pkt_start && (r1_sent < 3);
      set_data(1, DW'(40'hC0 + r1_sent));
      req_last[1]  = (r1_sent == 2);
      req_valid[3:2] = '0;
      #2;
      if (winc && n_w < 5) begin
        ids[n_w] = grant_id;
        n_w++;
      end
      if (req_valid[0] && req_ready[0]) begin
        r0_sent++; r0_left--; pkt_start = 1;
      end
      if (req_valid[1] && req_ready[1]) r1_sent++;
    end
`ifdef ARB_PKT_LOCK_EN
    exp_ids = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
`else
    exp_ids = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd1};
`endif
    chk("pkt_nwrites", n_w, 5);
    for (int k = 0; k < 5; k++)
      if (k < n_w) chk($sformatf("pkt_id%0d", k), ids[k], exp_ids[k]);

    // Random valid/wfull against the reference model and scoreboard.
    do_reset();
    for (int i = 0; i < N; i++) hs[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      cyc();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || hs[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < 55);
          set_data(i, DW'({$urandom, $urandom}));
          req_last[i]  = ($urandom_range(0, 2) == 0);
        end
      end
      wfull = ($urandom_range(0, 99) < 30);
      #2;
      for (int i = 0; i < N; i++) hs[i] = req_valid[i] & req_ready[i];
      model_check();
    end
    for (int c = 0; c < 4; c++) begin
      cyc();
      req_valid = '0;
      wfull     = 1'b0;
      #2;
      model_check();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
